// File: rtl/inst_fetch.sv
// ============================================================================
// inst_fetch -- instruction-fetch stage of the OpenMIPS pipeline.
//
// Owns the program counter, drives the combinational instruction ROM and
// registers the fetched {pc, inst} pair into the IF/ID pipeline register.
// Handles stall, branch redirect and flush, inserts bubbles, and counts the
// real instructions handed to decode.
//
// Parameters:
//   RESET_PC  PC loaded on reset and first address fetched
//   NOP_INST  instruction word used for bubbles (sll $0,$0,0)
//
// Optional feature (compile-time macro INST_FETCH_ALIGN_CHECK_EN):
//   defined     -> a misaligned PC (pc[1:0] != 0) delivers a NOP slot with
//                  id_valid=1 and id_adel=1 so decode can raise AdEL.
//   not defined -> id_adel is always 0 and pc[1:0] is ignored by the ROM.
//
// Ports:
//   clk            in   1   single clock, all state on rising edge
//   rst_n          in   1   asynchronous, active-low reset
//   stall_if       in   1   hold PC (IF cannot advance)
//   stall_id       in   1   hold IF/ID register (ID cannot accept)
//   branch_flag    in   1   redirect request from ID
//   branch_target  in   32  redirect address
//   flush          in   1   pipeline flush (exception/eret)
//   flush_pc       in   32  restart address on flush
//   chip_en        out  1   ROM chip enable
//   inst_addr      out  32  ROM byte address (= current PC)
//   inst           in   32  ROM data, valid same cycle as inst_addr
//   id_pc          out  32  IF/ID: PC of instruction in decode
//   id_inst        out  32  IF/ID: instruction word
//   id_valid       out  1   IF/ID holds a real instruction (0 = bubble)
//   id_adel        out  1   IF/ID: fetch address error
//   fetch_count    out  32  instructions delivered to ID since reset
//
// Handshake: there is no ready signal back from decode; stall_id plays that
// role. A slot with id_valid=1 is consumed by decode on every rising edge
// where stall_id=0. While stall_id=1 the slot (valid or bubble) is held
// unchanged and the PC is held as well.
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        chip_en,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        id_adel,
    output logic [31:0] fetch_count
);

    logic        r_chip_en;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;
    logic        r_id_adel;
    logic [31:0] r_fetch_count;

    logic [31:0] w_next_pc;
    logic        w_load;
    logic        w_hold;
    logic        w_misaligned;
    logic [31:0] w_load_inst;

    // Next-PC selection. Flush beats everything; a stall on either stage
    // freezes the PC (a branch seen during the stall is dropped, ID keeps
    // branch_flag asserted until the stall clears). The PC only starts to
    // move once the ROM has been enabled for a cycle.
    always_comb begin
        w_next_pc = r_pc + 32'd4;
        if (!r_chip_en) begin
            w_next_pc = r_pc;
        end else if (flush) begin
            w_next_pc = flush_pc;
        end else if (stall_if || stall_id) begin
            w_next_pc = r_pc;
        end else if (branch_flag) begin
            w_next_pc = branch_target;
        end
    end

    // IF/ID slot control: hold only when ID is stalled and no flush is
    // pending; load only when nothing stalls; every other case is a bubble.
    assign w_hold = r_chip_en && !flush && stall_id;
    assign w_load = r_chip_en && !flush && !stall_id && !stall_if;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_load_inst = w_misaligned ? NOP_INST : inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chip_en <= 1'b0;
            r_pc      <= RESET_PC;
        end else begin
            r_chip_en <= 1'b1;
            r_pc      <= w_next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            r_id_adel  <= 1'b0;
        end else if (w_load) begin
            r_id_pc    <= r_pc;
            r_id_inst  <= w_load_inst;
            r_id_valid <= 1'b1;
            r_id_adel  <= w_misaligned;
        end else if (!w_hold) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
            r_id_adel  <= 1'b0;
        end
    end

    // Counts every slot handed to decode, including address-error slots;
    // flush does not touch it, and it wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'h0000_0000;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign chip_en     = r_chip_en;
    assign inst_addr   = r_pc;
    assign id_pc       = r_id_pc;
    assign id_inst     = r_id_inst;
    assign id_valid    = r_id_valid;
    assign id_adel     = r_id_adel;
    assign fetch_count = r_fetch_count;

endmodule
